sata_prd_fetch: RTL
===================

SATA_PRD_FETCH -- requirements
Module: sata_prd_fetch

Interface
REQ-001 Parameter C_MAX_CHUNK, default 32768, max bytes per DMA segment; power of 2, 4..32768.
REQ-002 Parameter C_PORT, default 0, port index; no functional effect.
REQ-003 sys_clk  in  1  sole clock; all state changes on rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 cmd_start  in  1  one-cycle pulse; begins PRD walk.
REQ-006 cmd_prdt_base  in  32  PRD table byte address; bits[6:0] must be 0.
REQ-007 cmd_prdt_len  in  16  number of PRD entries.
REQ-008 cmd_wrt  in  1  transfer direction, copied to dma_wrt.
REQ-009 cmd_abort  in  1  level; requests termination.
REQ-010 cmd_busy  out  1  high from accepted start until done/err pulse.
REQ-011 cmd_done / cmd_err  out  1 each  one-cycle completion pulses, mutually exclusive.
REQ-012 cmd_xfer_cnt  out  32  bytes acknowledged by DMA this command.
REQ-013 prd_irq  out  1  one-cycle pulse when an entry with I=1 completes.
REQ-014 md_req / md_addr  out  1 / 32  table read request, 4-word burst.
REQ-015 md_ack / md_rvalid / md_rdata  in  1 / 1 / 32  request accept, read word valid, read word.
REQ-016 dma_req, dma_address[31:0], dma_length[15:0], dma_wrt, dma_sof, dma_eof  out  segment request to dma block.
REQ-017 dma_ack  in  1  one-cycle segment-complete pulse.

Function
REQ-018 States: IDLE, FETCH_REQ, FETCH_DATA, CHECK, ISSUE, NEXT, FINISH, FAIL.
REQ-019 IDLE: cmd_start latches base/len/wrt, clears idx and xfer_cnt, sets busy, goes to FETCH_REQ (or FINISH if len=0, no memory access). Start while busy is ignored.
REQ-020 FETCH_REQ: md_req=1, md_addr=base+16*idx; both held stable until md_ack; then FETCH_DATA.
REQ-021 FETCH_DATA: capture 4 md_rvalid words in order DBA, DBAU, reserved, DW3; gaps allowed; then CHECK.
REQ-022 CHECK: bytes=DW3[21:0]+1 (23-bit); err if DBAU!=0, DBA[0]!=0, or DW3[0]=0; err -> FAIL, else ISSUE with addr=DBA, rem=bytes.
REQ-023 ISSUE: dma_req=1, dma_length=min(rem,C_MAX_CHUNK), dma_address=addr; all dma_* fields stable until dma_ack.
REQ-024 dma_sof=1 only on first segment of command; dma_eof=1 only on segment leaving rem=0 for idx=len-1.
REQ-025 On dma_ack: addr+=chunk, rem-=chunk, xfer_cnt+=chunk (32-bit wrap); dma_req low next cycle; rem>0 -> ISSUE after one idle cycle, else NEXT.
REQ-026 NEXT: prd_irq pulse if I=DW3[31]; idx+1; idx=len -> FINISH, else FETCH_REQ.
REQ-027 FINISH: cmd_done pulse, busy low, -> IDLE. FAIL: cmd_err pulse, busy low, -> IDLE.
REQ-028 cmd_abort honoured only at boundaries: in FETCH_REQ before md_ack, in CHECK, NEXT, or ISSUE before dma_req asserted -> FAIL; an accepted md burst or issued dma_req completes first.
REQ-029 Abort and error in same cycle -> single cmd_err; abort in IDLE ignored; abort+start in IDLE -> start ignored.
REQ-030 md_ack/md_rvalid/dma_ack outside their states are ignored.

Reset
REQ-031 sys_rst in any state -> IDLE next edge; all outputs 0, xfer_cnt 0, pending handshakes dropped without pulses.

Structure
REQ-032 Package sata_prd_pkg holds state enum, PRD word offsets (0..3), DW3 field positions (DBC [21:0], I bit 31), C_MAX_CHUNK default.
REQ-033 Single module; no sub-module warranted. Chunk min and address arithmetic inline, registered outputs.

Verification
REQ-034 len=1, DBA=0x1000, DBC=0x1FF -> one segment addr 0x1000 len 512 sof=eof=1, done, xfer_cnt=512.
REQ-035 len=1, DBC=0x11FFF (73728 B), C_MAX_CHUNK=32768 -> segments 32768@0x0, 32768@0x8000, 8192@0x10000; eof only last.
REQ-036 len=3, I=1 on entry 1 only -> md_addr base, base+16, base+32; single prd_irq after entry 1 last ack.
REQ-037 DBAU=1 or DBC=0x100 (odd bytes) -> no dma_req, cmd_err, busy low.
REQ-038 cmd_abort during outstanding dma_req -> waits for dma_ack, then cmd_err, no further md_req.
REQ-039 len=0 -> cmd_done 2 cycles after start, no md_req; sys_rst mid-ISSUE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sata_prd_pkg.sv
// rtl/sata_prd_pkg.sv - shared state encoding and PRD layout constants for the PRD walker
package sata_prd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_DATA,
    S_CHECK,
    S_ISSUE,
    S_NEXT,
    S_FINISH,
    S_FAIL
  } prd_state_t;

  localparam logic [1:0] PRD_DW_DBA  = 2'd0;
  localparam logic [1:0] PRD_DW_DBAU = 2'd1;
  localparam logic [1:0] PRD_DW_RSVD = 2'd2;
  localparam logic [1:0] PRD_DW_DW3  = 2'd3;

  localparam int DW3_DBC_MSB = 21;
  localparam int DW3_I_BIT   = 31;

  localparam int PRD_MAX_CHUNK_DEF = 32768;

endpackage

// File: rtl/sata_prd_fetch.sv
// rtl/sata_prd_fetch.sv - walks a PRD table, validates each entry and issues chunked DMA segments
module sata_prd_fetch
  import sata_prd_pkg::*;
#(
  parameter int C_MAX_CHUNK = PRD_MAX_CHUNK_DEF,
  parameter int C_PORT      = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_start,
  input  logic [31:0] cmd_prdt_base,
  input  logic [15:0] cmd_prdt_len,
  input  logic        cmd_wrt,
  input  logic        cmd_abort,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [31:0] cmd_xfer_cnt,
  output logic        prd_irq,
  output logic        md_req,
  output logic [31:0] md_addr,
  input  logic        md_ack,
  input  logic        md_rvalid,
  input  logic [31:0] md_rdata,
  output logic        dma_req,
  output logic [31:0] dma_address,
  output logic [15:0] dma_length,
  output logic        dma_wrt,
  output logic        dma_sof,
  output logic        dma_eof,
  input  logic        dma_ack
);

  if (C_MAX_CHUNK < 4 || C_MAX_CHUNK > 32768 ||
      (C_MAX_CHUNK & (C_MAX_CHUNK - 1)) != 0 || C_PORT < 0) begin : g_param_check
    $error("sata_prd_fetch: illegal parameter value");
  end

  localparam logic [22:0] LP_CHUNK = 23'(C_MAX_CHUNK);

  prd_state_t  r_state, w_next;
  logic [31:0] r_base;
  logic [15:0] r_len, r_idx;
  logic        r_wrt, r_first;
  logic [1:0]  r_word;
  logic [31:0] r_dba;
  logic        r_dbau_nz;
  logic [21:0] r_dbc;
  logic        r_irq_bit;
  logic [31:0] r_addr;
  logic [22:0] r_rem;

  logic        r_busy, r_done, r_err, r_irq;
  logic [31:0] r_xfer_cnt;
  logic        r_md_req;
  logic [31:0] r_md_addr;
  logic        r_dma_req, r_dma_wrt, r_dma_sof, r_dma_eof;
  logic [31:0] r_dma_address;
  logic [15:0] r_dma_length;

  logic [22:0] w_chunk, w_rem_after;
  logic [15:0] w_idx_inc;
  logic [31:0] w_md_addr;
  logic        w_last_entry, w_prd_err;
  logic        w_accept, w_md_launch, w_md_accept, w_word_cap, w_seg_load;
  logic        w_dma_launch, w_dma_done, w_idx_step, w_irq, w_done, w_err;

  assign w_chunk      = (r_rem > LP_CHUNK) ? LP_CHUNK : r_rem;
  assign w_rem_after  = r_rem - w_chunk;
  assign w_idx_inc    = r_idx + 16'd1;
  assign w_last_entry = (r_idx == r_len - 16'd1);
  assign w_prd_err    = r_dbau_nz | r_dba[0] | ~r_dbc[0];
  // First entry address comes straight from the command; later ones from the latched base
  assign w_md_addr    = (r_state == S_IDLE) ? cmd_prdt_base
                                            : r_base + {12'd0, w_idx_inc, 4'd0};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (cmd_start && !cmd_abort)
                      w_next = (cmd_prdt_len == 16'd0) ? S_FINISH : S_FETCH_REQ;
      S_FETCH_REQ:  if (md_ack) w_next = S_FETCH_DATA;
                    else if (cmd_abort) w_next = S_FAIL;
      S_FETCH_DATA: if (md_rvalid && r_word == PRD_DW_DW3) w_next = S_CHECK;
      S_CHECK:      w_next = (cmd_abort || w_prd_err) ? S_FAIL : S_ISSUE;
      S_ISSUE: begin
        if (r_dma_req) begin
          if (dma_ack) w_next = (w_rem_after == 23'd0) ? S_NEXT : S_ISSUE;
        end else if (cmd_abort) begin
          w_next = S_FAIL;
        end
      end
      S_NEXT:       if (cmd_abort) w_next = S_FAIL;
                    else w_next = (w_idx_inc == r_len) ? S_FINISH : S_FETCH_REQ;
      S_FINISH:     w_next = S_IDLE;
      S_FAIL:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept     = (r_state == S_IDLE) && (w_next != S_IDLE);
    w_md_launch  = (w_next == S_FETCH_REQ) && (r_state != S_FETCH_REQ);
    w_md_accept  = (r_state == S_FETCH_REQ) && md_ack;
    w_word_cap   = (r_state == S_FETCH_DATA) && md_rvalid;
    w_seg_load   = (r_state == S_CHECK) && (w_next == S_ISSUE);
    w_dma_launch = (r_state == S_ISSUE) && !r_dma_req && (w_next == S_ISSUE);
    w_dma_done   = (r_state == S_ISSUE) && r_dma_req && dma_ack;
    w_idx_step   = (r_state == S_NEXT);
    w_irq        = (r_state == S_NEXT) && r_irq_bit;
    w_done       = (r_state == S_FINISH);
    w_err        = (r_state == S_FAIL);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_base <= '0; r_len <= '0; r_idx <= '0; r_wrt <= 1'b0; r_first <= 1'b0;
      r_word <= '0; r_dba <= '0; r_dbau_nz <= 1'b0; r_dbc <= '0; r_irq_bit <= 1'b0;
      r_addr <= '0; r_rem <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0; r_irq <= 1'b0; r_xfer_cnt <= '0;
      r_md_req <= 1'b0; r_md_addr <= '0;
      r_dma_req <= 1'b0; r_dma_address <= '0; r_dma_length <= '0;
      r_dma_wrt <= 1'b0; r_dma_sof <= 1'b0; r_dma_eof <= 1'b0;
    end else begin
      r_done <= w_done;
      r_err  <= w_err;
      r_irq  <= w_irq;
      if (w_accept) begin
        r_base     <= cmd_prdt_base;
        r_len      <= cmd_prdt_len;
        r_wrt      <= cmd_wrt;
        r_idx      <= '0;
        r_xfer_cnt <= '0;
        r_first    <= 1'b1;
        r_busy     <= 1'b1;
      end
      if (w_done || w_err) r_busy <= 1'b0;
      if (w_md_launch) begin
        r_md_req  <= 1'b1;
        r_md_addr <= w_md_addr;
      end
      if (w_md_accept) begin
        r_md_req <= 1'b0;
        r_word   <= '0;
      end
      if (w_word_cap) begin
        r_word <= r_word + 2'd1;
        case (r_word)
          PRD_DW_DBA:  r_dba <= md_rdata;
          PRD_DW_DBAU: r_dbau_nz <= |md_rdata;
          PRD_DW_RSVD: ;
          PRD_DW_DW3: begin
            r_dbc     <= md_rdata[DW3_DBC_MSB:0];
            r_irq_bit <= md_rdata[DW3_I_BIT];
          end
          default: ;
        endcase
      end
      if (w_seg_load) begin
        r_addr <= r_dba;
        r_rem  <= {1'b0, r_dbc} + 23'd1;
      end
      if (w_dma_launch) begin
        r_dma_req     <= 1'b1;
        r_dma_address <= r_addr;
        r_dma_length  <= w_chunk[15:0];
        r_dma_wrt     <= r_wrt;
        r_dma_sof     <= r_first;
        r_dma_eof     <= (w_rem_after == 23'd0) && w_last_entry;
      end
      if (w_dma_done) begin
        r_dma_req     <= 1'b0;
        r_dma_address <= '0;
        r_dma_length  <= '0;
        r_dma_wrt     <= 1'b0;
        r_dma_sof     <= 1'b0;
        r_dma_eof     <= 1'b0;
        r_addr        <= r_addr + {9'd0, w_chunk};
        r_rem         <= w_rem_after;
        r_xfer_cnt    <= r_xfer_cnt + {9'd0, w_chunk};
        r_first       <= 1'b0;
      end
      if (w_idx_step) r_idx <= w_idx_inc;
    end
  end

  assign cmd_busy     = r_busy;
  assign cmd_done     = r_done;
  assign cmd_err      = r_err;
  assign cmd_xfer_cnt = r_xfer_cnt;
  assign prd_irq      = r_irq;
  assign md_req       = r_md_req;
  assign md_addr      = r_md_addr;
  assign dma_req      = r_dma_req;
  assign dma_address  = r_dma_address;
  assign dma_length   = r_dma_length;
  assign dma_wrt      = r_dma_wrt;
  assign dma_sof      = r_dma_sof;
  assign dma_eof      = r_dma_eof;

endmodule
